// File: rtl/swap_pkg.sv
// Shared state encoding and default widths for the register-file swap sequencer.
package swap_pkg;

  localparam int unsigned SWAP_ADDR_WIDTH = 7;
  localparam int unsigned SWAP_DATA_WIDTH = 8;
  localparam int unsigned SWAP_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_DONE = 3'd5
  } swap_state_e;

endpackage

// File: rtl/swap_ctrl.sv
// Exchanges two register-file entries: read A, read B, write B's value to A, then A's value to B.
// All outputs are decoded from registered state, so nothing on start/addr_* reaches an output combinationally.
module swap_ctrl
  import swap_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = SWAP_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SWAP_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = SWAP_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  ready,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  input  logic [DATA_WIDTH-1:0] mem_data_r,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic [2:0]            dbg_state
);

  // Handshake: a request is taken on a rising edge where start && ready;
  // ready is high only in IDLE, so start while busy is simply dropped.

  swap_state_e           state_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [ADDR_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] tmp_a_q;
  logic [DATA_WIDTH-1:0] tmp_b_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

  // Saturating count: holds at all-ones instead of wrapping.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= addr_a;
            b_q     <= addr_b;
            state_q <= (addr_a == addr_b) ? ST_DONE : ST_RD_A;
          end
        end
        ST_RD_A: begin
          tmp_a_q <= mem_data_r;
          state_q <= ST_RD_B;
        end
        ST_RD_B: begin
          tmp_b_q <= mem_data_r;
          state_q <= ST_WR_A;
        end
        ST_WR_A: state_q <= ST_WR_B;
        ST_WR_B: state_q <= ST_DONE;
        ST_DONE: begin
          cnt_q   <= cnt_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready      = (state_q == ST_IDLE);
    done       = (state_q == ST_DONE);
    mem_we     = 1'b0;
    mem_addr_r = '0;
    mem_addr_w = '0;
    mem_data_w = '0;
    case (state_q)
      ST_RD_A: mem_addr_r = a_q;
      ST_RD_B: mem_addr_r = b_q;
      ST_WR_A: begin
        mem_we     = 1'b1;
        mem_addr_w = a_q;
        mem_data_w = tmp_b_q;
      end
      ST_WR_B: begin
        mem_we     = 1'b1;
        mem_addr_w = b_q;
        mem_data_w = tmp_a_q;
      end
      default: ;
    endcase
  end

  assign swap_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_swap_ctrl.sv
// Directed bench for swap_ctrl with a behavioural register file and a 2-bit-counter instance.
module tb_swap_ctrl;
  import swap_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic [AW-1:0] addr_a, addr_b;
  logic          ready, done, mem_we;
  logic [AW-1:0] mem_addr_w, mem_addr_r;
  logic [DW-1:0] mem_data_w, mem_data_r;
  logic [CW-1:0] swap_count;
  logic [2:0]    dbg_state;

  logic          start_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_r_s;
  logic          ready_s, done_s, we_s;
  logic [AW-1:0] addr_w_s, addr_r_s;
  logic [DW-1:0] data_w_s;
  logic [1:0]    count_s;
  logic [2:0]    dbg_s;

  swap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr_a(addr_a), .addr_b(addr_b),
    .ready(ready), .done(done), .mem_we(mem_we), .mem_addr_w(mem_addr_w),
    .mem_data_w(mem_data_w), .mem_addr_r(mem_addr_r), .mem_data_r(mem_data_r),
    .swap_count(swap_count), .dbg_state(dbg_state)
  );

  swap_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start_s), .addr_a(addr_s), .addr_b(addr_s),
    .ready(ready_s), .done(done_s), .mem_we(we_s), .mem_addr_w(addr_w_s),
    .mem_data_w(data_w_s), .mem_addr_r(addr_r_s), .mem_data_r(data_r_s),
    .swap_count(count_s), .dbg_state(dbg_s)
  );

  // register file model with a preload write mux
  logic [DW-1:0] mem [0:127];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  assign mem_data_r = mem[mem_addr_r];
  always @(posedge clk) begin
    if (mem_we)      mem[mem_addr_w] <= mem_data_w;
    else if (pre_we) mem[pre_addr]   <= pre_data;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b);
    start = 1'b1; addr_a = a; addr_b = b;
    @(negedge clk);
  endtask

  int done_at, done2_at, done_cnt, we_cnt, ready_at;
  logic [AW-1:0] ar_log [0:15];
  logic [AW-1:0] aw_log [0:15];
  logic [DW-1:0] dw_log [0:15];
  logic          we_log [0:15];

  // Samples cycles 1..ncyc after acceptance; start is held for i < hold_until
  // and pulsed with addresses 4/5 at i == inj_at.
  task automatic watch(input int ncyc, input int hold_until, input int inj_at);
    done_at = 0; done2_at = 0; done_cnt = 0; we_cnt = 0; ready_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      start = (i < hold_until) || (i == inj_at);
      if (i == inj_at) begin addr_a = 7'd4; addr_b = 7'd5; end
      ar_log[i] = mem_addr_r; aw_log[i] = mem_addr_w;
      dw_log[i] = mem_data_w; we_log[i] = mem_we;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
        else if (done2_at == 0) done2_at = i;
      end
      if (mem_we) we_cnt++;
      if (ready && ready_at == 0) ready_at = i;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    start = 1'b0; addr_a = '0; addr_b = '0;
    start_s = 1'b0; addr_s = '0; data_r_s = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 128; i++) mem[i] = '0;

    // 1: reset values, during and after reset
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_count", swap_count, 0);
    chk("rst_outs", {mem_addr_r, mem_addr_w, mem_data_w}, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_done", done, 0);

    // 2: basic swap
    preload(7'd3, 8'hAA);
    preload(7'd90, 8'h55);
    issue(7'd3, 7'd90);
    watch(6, 0, 0);
    chk("basic_done_at", done_at, 5);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_we_cnt", we_cnt, 2);
    chk("basic_ready_at", ready_at, 6);
    chk("basic_rd_a", ar_log[1], 3);
    chk("basic_rd_b", ar_log[2], 90);
    chk("basic_rd_idle", ar_log[3], 0);
    chk("basic_wr_a", {we_log[3], aw_log[3], dw_log[3]}, {1'b1, 7'd3, 8'h55});
    chk("basic_wr_b", {we_log[4], aw_log[4], dw_log[4]}, {1'b1, 7'd90, 8'hAA});
    chk("basic_done_outs", {we_log[5], aw_log[5], dw_log[5]}, 0);
    chk("basic_mem3", mem[3], 8'h55);
    chk("basic_mem90", mem[90], 8'hAA);
    chk("basic_count", swap_count, 1);

    // 3: same address
    preload(7'd7, 8'h3C);
    issue(7'd7, 7'd7);
    watch(4, 0, 0);
    chk("same_done_at", done_at, 1);
    chk("same_we_cnt", we_cnt, 0);
    chk("same_ready_at", ready_at, 2);
    chk("same_mem7", mem[7], 8'h3C);
    chk("same_count", swap_count, 2);

    // 4: start during RD_B is ignored
    preload(7'd1, 8'h11);
    preload(7'd2, 8'h22);
    preload(7'd4, 8'h44);
    preload(7'd5, 8'h55);
    issue(7'd1, 7'd2);
    watch(8, 0, 2);
    chk("busy_done_cnt", done_cnt, 1);
    chk("busy_we_cnt", we_cnt, 2);
    chk("busy_mem1", mem[1], 8'h22);
    chk("busy_mem2", mem[2], 8'h11);
    chk("busy_mem4", mem[4], 8'h44);
    chk("busy_mem5", mem[5], 8'h55);
    chk("busy_count", swap_count, 3);

    // 5: back-to-back with start held
    preload(7'd0, 8'h5A);
    preload(7'd127, 8'hC3);
    issue(7'd0, 7'd127);
    watch(12, 7, 0);
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_done_at", done_at, 5);
    chk("b2b_done2_at", done2_at, 11);
    chk("b2b_we_cnt", we_cnt, 4);
    chk("b2b_mem0", mem[0], 8'h5A);
    chk("b2b_mem127", mem[127], 8'hC3);
    chk("b2b_count", swap_count, 5);

    // 6: reset during WR_B
    preload(7'd10, 8'hA1);
    preload(7'd20, 8'hB2);
    issue(7'd10, 7'd20);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_in_wr_b", {mem_we, mem_addr_w}, {1'b1, 7'd20});
    #2 rst_n = 1'b0;
    #1;
    chk("mid_we_async", mem_we, 0);
    chk("mid_done", done, 0);
    chk("mid_ready", ready, 1);
    chk("mid_count", swap_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    watch(3, 0, 0);
    chk("mid_no_done", done_cnt, 0);
    chk("mid_no_we", we_cnt, 0);
    chk("mid_ready_after", ready_at, 1);
    chk("mid_mem_a", mem[10], 8'hB2);
    chk("mid_mem_b", mem[20], 8'hB2);

    // saturation on the 2-bit counter instance
    start_s = 1'b1;
    repeat (4) @(negedge clk);
    chk("sat_count_2", count_s, 2);
    repeat (6) @(negedge clk);
    start_s = 1'b0;
    chk("sat_count_5", count_s, 2'b11);
    chk("sat_we", we_s, 0);
    repeat (2) @(negedge clk);
    chk("sat_hold", count_s, 2'b11);
    chk("sat_ready", ready_s, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
